// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath stages.
// Holds the state encoding used by signed_minmax_tracker.
// No ports; imported with import alu_pkg::*.
package alu_pkg;

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_ACCUM = 2'd1,
        MM_HOLD  = 2'd2
    } minmax_state_t;

endpackage

// File: rtl/signed_comparator.sv
// Two's-complement magnitude comparator, purely combinational.
// Ports: a, b (SIZE-bit signed operands); greater = a > b, equal = a == b.
// Signed order is obtained by flipping the sign bits and comparing unsigned.
module signed_comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            greater,
    output logic            equal
);

    logic [SIZE-1:0] a_bias;
    logic [SIZE-1:0] b_bias;

    // Inverting the MSB maps -2^(SIZE-1)..2^(SIZE-1)-1 onto 0..2^SIZE-1 monotonically.
    assign a_bias  = {~a[SIZE-1], a[SIZE-2:0]};
    assign b_bias  = {~b[SIZE-1], b[SIZE-2:0]};
    assign greater = (a_bias > b_bias);
    assign equal   = (a == b);

endmodule

// File: rtl/signed_minmax_tracker.sv
// Running signed min/max and saturating beat count over a valid/ready frame.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last input stream;
//        out_valid/out_ready with out_min, out_max, out_count, out_eq held until taken.
// Result appears the cycle after the last beat is accepted; input stalls while a result is held.
module signed_minmax_tracker
    import alu_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZE-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    out_min,
    output logic [SIZE-1:0]    out_max,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_eq
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    minmax_state_t      state;
    logic [SIZE-1:0]    min_q, max_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               eq_q;

    logic [SIZE-1:0]    min_nxt, max_nxt;
    logic [COUNT_W-1:0] cnt_nxt;
    logic               accept;
    logic               new_gt_max, new_eq_max;
    logic               new_gt_min, new_eq_min;
    logic               mm_equal;
    logic               unused_mm_greater;
    logic               unused_new_eq_max;

    // Handshake outputs come straight from the state register; rst only gates ready low.
    assign in_ready  = !rst && (state != MM_HOLD);
    assign out_valid = (state == MM_HOLD);
    assign accept    = in_valid && in_ready;

    signed_comparator #(.SIZE(SIZE)) u_cmp_max (
        .a       (in_data),
        .b       (max_q),
        .greater (new_gt_max),
        .equal   (new_eq_max)
    );

    signed_comparator #(.SIZE(SIZE)) u_cmp_min (
        .a       (in_data),
        .b       (min_q),
        .greater (new_gt_min),
        .equal   (new_eq_min)
    );

    // Compares the values about to be stored so out_eq lines up with out_min/out_max.
    signed_comparator #(.SIZE(SIZE)) u_cmp_eq (
        .a       (min_nxt),
        .b       (max_nxt),
        .greater (unused_mm_greater),
        .equal   (mm_equal)
    );

    assign unused_new_eq_max = new_eq_max;

    always_comb begin
        min_nxt = min_q;
        max_nxt = max_q;
        cnt_nxt = cnt_q;
        if (accept) begin
            if (state == MM_IDLE) begin
                min_nxt = in_data;
                max_nxt = in_data;
                cnt_nxt = COUNT_W'(1);
            end else begin
                // Strict comparisons: a tie leaves the stored extreme untouched.
                if (new_gt_max)
                    max_nxt = in_data;
                if (!new_gt_min && !new_eq_min)
                    min_nxt = in_data;
                if (cnt_q != CNT_MAX)
                    cnt_nxt = cnt_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MM_IDLE;
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            eq_q  <= 1'b0;
        end else begin
            min_q <= min_nxt;
            max_q <= max_nxt;
            cnt_q <= cnt_nxt;
            // Only refreshed on an accept, so it reads 0 after reset until data arrives.
            if (accept)
                eq_q <= mm_equal;
            case (state)
                MM_IDLE: begin
                    if (accept)
                        state <= in_last ? MM_HOLD : MM_ACCUM;
                end
                MM_ACCUM: begin
                    if (accept && in_last)
                        state <= MM_HOLD;
                end
                MM_HOLD: begin
                    if (out_ready)
                        state <= MM_IDLE;
                end
                default: state <= MM_IDLE;
            endcase
        end
    end

    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = cnt_q;
    assign out_eq    = eq_q;

endmodule
